// File: rtl/rescale_round_pipe.sv
// rescale_round_pipe: two-stage signed divide-by-2^SHIFT with per-beat rounding and saturation.
// Optional saturation event counter enabled by defining RESCALE_SAT_CNT_EN.
`default_nettype none

module rescale_round_pipe #(
   parameter int IN_W  = 42,
   parameter int OUT_W = 22,
   parameter int SHIFT = 20,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic [1:0]              in_mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sat,
   input  logic                    sat_clr,
   output logic [CNT_W-1:0]        sat_count
);

   localparam int QW = IN_W - SHIFT;
   localparam int RW = QW + 2;
   localparam logic [SHIFT-1:0]     c_half = SHIFT'(1) << (SHIFT - 1);
   localparam logic signed [RW-1:0] c_max  = $signed({{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [RW-1:0] c_min  = ~c_max;

   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_neg_q,   s1_neg_d;
   logic [QW-1:0]           s1_quo_q,   s1_quo_d;
   logic [SHIFT-1:0]        s1_rem_q,   s1_rem_d;
   logic [1:0]              s1_mode_q,  s1_mode_d;
   logic                    s2_valid_q, s2_valid_d;
   logic signed [OUT_W-1:0] s2_data_q,  s2_data_d;
   logic                    s2_sat_q,   s2_sat_d;

   logic                    w_adv1, w_adv2;
   logic                    w_neg;
   logic [IN_W-1:0]         w_mag;
   logic                    w_up;
   logic [QW:0]             w_rmag;
   logic signed [RW-1:0]    w_ext, w_val;
   logic                    w_sat_hi, w_sat_lo;
   logic signed [OUT_W-1:0] w_res;

   assign w_adv2   = ~s2_valid_q | out_ready;
   assign w_adv1   = ~s1_valid_q | w_adv2;
   assign in_ready = w_adv1;

   // Magnitude is unsigned IN_W so the most negative input maps exactly.
   assign w_neg = in_data[IN_W-1];
   assign w_mag = w_neg ? (~in_data + IN_W'(1)) : in_data;

   always_comb begin
      w_up = 1'b0;
      case (s1_mode_q)
         2'd0:    w_up = (s1_rem_q >= c_half);
         2'd1:    w_up = 1'b0;
         2'd2:    w_up = (s1_rem_q > c_half) | ((s1_rem_q == c_half) & s1_quo_q[0]);
         default: w_up = s1_neg_q & (|s1_rem_q);
      endcase
   end

   assign w_rmag   = {1'b0, s1_quo_q} + {{QW{1'b0}}, w_up};
   assign w_ext    = $signed({1'b0, w_rmag});
   assign w_val    = s1_neg_q ? -w_ext : w_ext;
   assign w_sat_hi = (w_val > c_max);
   assign w_sat_lo = (w_val < c_min);
   assign w_res    = w_sat_hi ? c_max[OUT_W-1:0] :
                     w_sat_lo ? c_min[OUT_W-1:0] : w_val[OUT_W-1:0];

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_neg_d   = s1_neg_q;
      s1_quo_d   = s1_quo_q;
      s1_rem_d   = s1_rem_q;
      s1_mode_d  = s1_mode_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_sat_d   = s2_sat_q;
      if (w_adv1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_neg_d  = w_neg;
            s1_quo_d  = w_mag[IN_W-1:SHIFT];
            s1_rem_d  = w_mag[SHIFT-1:0];
            s1_mode_d = in_mode;
         end
      end
      // Output registers only change when a beat moves in, so stalled data holds.
      if (w_adv2) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = w_res;
            s2_sat_d  = w_sat_hi | w_sat_lo;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_neg_q   <= 1'b0;
         s1_quo_q   <= '0;
         s1_rem_q   <= '0;
         s1_mode_q  <= 2'd0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_sat_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_neg_q   <= s1_neg_d;
         s1_quo_q   <= s1_quo_d;
         s1_rem_q   <= s1_rem_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_sat_q   <= s2_sat_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_sat   = s2_sat_q;

`ifdef RESCALE_SAT_CNT_EN
   logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

   // Clear takes priority; the counter sticks at all-ones.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (sat_clr)
         sat_cnt_d = '0;
      else if (s2_valid_q & out_ready & s2_sat_q & ~(&sat_cnt_q))
         sat_cnt_d = sat_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_cnt_q <= '0;
      else     sat_cnt_q <= sat_cnt_d;
   end

   assign sat_count = sat_cnt_q;
`else
   logic unused_sat_clr;
   assign unused_sat_clr = sat_clr;
   assign sat_count      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rescale_round_pipe.sv
// tb_rescale_round_pipe: scoreboard bench with directed vectors for rescale_round_pipe.
`default_nettype none

module tb_rescale_round_pipe;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [41:0] in_data;
   logic [1:0]         in_mode;
   logic               out_valid;
   logic               out_ready;
   logic signed [21:0] out_data;
   logic               out_sat;
   logic               sat_clr;
   logic [15:0]        sat_count;

   rescale_round_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .sat_clr   (sat_clr),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [21:0] d;
      logic               s;
      int                 cyc;
      bit                 lat;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_acc   = 0;
   bit   chk_lat = 1'b0;
   bit   sdone;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic send(input logic signed [41:0] d, input logic [1:0] m,
                       input logic signed [21:0] e, input logic s);
      exp_t x;
      int   w;
      in_data  = d;
      in_mode  = m;
      in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
      end else begin
         x.d = e; x.s = s; x.cyc = cyc; x.lat = chk_lat;
         sb.push_back(x);
         n_acc++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_mode  = 2'd0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("drain_remaining", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expectations when a beat is taken and checks hold under stall.
   logic               held_v = 1'b0;
   logic signed [21:0] held_d;
   logic               held_s;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held_d);
            chk("hold_sat", out_sat, held_s);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_data", out_data, e.d);
               chk("out_sat", out_sat, e.s);
               if (e.lat) chk("latency", cyc, e.cyc + 2);
            end
         end
         held_v = out_valid && !out_ready;
         held_d = out_data;
         held_s = out_sat;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic signed [41:0] c_pmax = {1'b0, {41{1'b1}}};
   localparam logic signed [41:0] c_nmin = {1'b1, 41'd0};

   initial begin
      int a0;
      int w;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 2'd0;
      out_ready = 1'b1;
      sat_clr   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_sat", out_sat, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_sat_count", sat_count, 0);
      @(posedge clk);
      #1;

      // Rounding modes, streamed back to back with latency checked.
      chk_lat = 1'b1;
      send(42'sd524288,   2'd0, 22'sd1,  1'b0);
      send(42'sd524287,   2'd0, 22'sd0,  1'b0);
      send(-42'sd524288,  2'd0, -22'sd1, 1'b0);
      send(42'sd1572864,  2'd0, 22'sd2,  1'b0);
      send(42'sd1572864,  2'd2, 22'sd2,  1'b0);
      send(42'sd524288,   2'd2, 22'sd0,  1'b0);
      send(42'sd2621440,  2'd2, 22'sd2,  1'b0);
      send(-42'sd1572864, 2'd1, -22'sd1, 1'b0);
      send(-42'sd1,       2'd3, -22'sd1, 1'b0);
      send(42'sd1,        2'd3, 22'sd0,  1'b0);
      send(-42'sd1,       2'd0, 22'sd0,  1'b0);
      send(-42'sd1572864, 2'd0, -22'sd2, 1'b0);
      // Saturation boundaries.
      send(c_pmax,        2'd0, 22'sd2097151,  1'b1);
      send(c_nmin,        2'd0, -22'sd2097152, 1'b0);
      send(c_pmax,        2'd1, 22'sd2097151,  1'b0);
      send(c_nmin + 42'sd1, 2'd3, -22'sd2097152, 1'b0);
      drain();

      // Backpressure: only two beats fit while the output is stalled.
      chk_lat   = 1'b0;
      out_ready = 1'b0;
      a0        = n_acc;
      sdone     = 1'b0;
      fork
         begin
            for (int k = 10; k < 15; k++)
               send(42'(k) <<< 20, 2'd0, 22'(k), 1'b0);
            sdone = 1'b1;
         end
      join_none
      repeat (5) @(negedge clk);
      chk("stall_accepts", n_acc - a0, 2);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_data", out_data, 10);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      w = 0;
      while (!sdone && w < 100) begin
         @(posedge clk);
         w++;
      end
      chk("stream_done", sdone, 1);
      drain();

      // Asynchronous reset with both stages holding beats.
      out_ready = 1'b0;
      send(42'sd3145728, 2'd0, 22'sd3, 1'b0);
      send(42'sd4194304, 2'd0, 22'sd4, 1'b0);
      chk("pre_reset_out_valid", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_out_valid", out_valid, 0);
      chk("async_reset_out_data", out_data, 0);
      sb.delete();
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk_lat = 1'b1;
      send(42'sd5242880, 2'd0, 22'sd5, 1'b0);
      drain();
      chk_lat = 1'b0;

`ifdef RESCALE_SAT_CNT_EN
      chk("cnt_after_reset", sat_count, 0);
      repeat (3) send(c_pmax, 2'd0, 22'sd2097151, 1'b1);
      drain();
      chk("cnt_three", sat_count, 3);
      sat_clr = 1'b1;
      send(c_pmax, 2'd0, 22'sd2097151, 1'b1);
      drain();
      chk("cnt_cleared", sat_count, 0);
      sat_clr = 1'b0;
`else
      send(c_pmax, 2'd0, 22'sd2097151, 1'b1);
      drain();
      chk("cnt_disabled", sat_count, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
